i2s_rx_mem_controller: RTL and testbench

Capture-side counterpart of the I2S playback memory controller. It accepts stereo samples from the I2S reader over a four-phase request/ack handshake and packs each sample into a 32-bit word. It writes the words into the write port of a ping-pong FIFO, which the wishbone side drains. It acquires and releases FIFO buffers and counts samples dropped when no buffer is available.

---
 rtl/i2s_rx_mem_controller.sv | 183 ++++++++++++++++++
 tb/tb_i2s_rx_mem_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_mem_controller.sv
// i2s_rx_mem_controller: capture-side memory controller.
// Takes stereo samples from the I2S reader over a four-phase request/ack
// handshake, packs each into {lr, 7'h00, data[23:0]} and writes the words into
// one half of a ping-pong FIFO. It acquires and releases buffers, and counts
// samples dropped while no buffer is available (saturating counter).
// Optional feature: define I2S_RX_FLUSH_TIMEOUT_EN to release a partially
// filled buffer after FLUSH_TIMEOUT idle clk cycles without a write.
module i2s_rx_mem_controller #(
  parameter int FLUSH_TIMEOUT  = 4096,
  parameter int OVERFLOW_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear_overflow,
  input  logic                      audio_data_request,
  input  logic [23:0]               audio_data,
  input  logic                      audio_lr_bit,
  output logic                      audio_data_ack,
  input  logic [1:0]                wfifo_ready,
  input  logic [23:0]               wfifo_size,
  output logic [1:0]                wfifo_activate,
  output logic                      wfifo_strobe,
  output logic [31:0]               wfifo_data,
  output logic [OVERFLOW_WIDTH-1:0] overflow_count,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [OVERFLOW_WIDTH-1:0] OVF_ONE = {{(OVERFLOW_WIDTH-1){1'b0}}, 1'b1};

  state_t                      state_reg, state_next;
  logic [23:0]                 count_reg, count_next;
  logic [1:0]                  activate_reg, activate_next;
  logic                        strobe_reg, strobe_next;
  logic [31:0]                 data_reg, data_next;
  logic                        ack_reg, ack_next;
  logic [OVERFLOW_WIDTH-1:0]   overflow_reg, overflow_next;

`ifdef I2S_RX_FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  logic [IDLE_W-1:0]           idle_reg, idle_next;
`endif

  // A request not yet acknowledged is the only thing that may be taken or dropped.
  logic        pending;
  logic [31:0] packed_word;
  assign pending     = audio_data_request && !ack_reg;
  assign packed_word = {audio_lr_bit, 7'h00, audio_data};

  // Next-state and registered-output logic for the buffer FSM and handshake.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    activate_next = activate_reg;
    strobe_next   = 1'b0;
    data_next     = data_reg;
    ack_next      = ack_reg;
    overflow_next = overflow_reg;
`ifdef I2S_RX_FLUSH_TIMEOUT_EN
    idle_next     = '0;
`endif

    // Ack drops one cycle after the reader lowers its request.
    if (ack_reg && !audio_data_request) begin
      ack_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (wfifo_ready != 2'b00) begin
          // Buffer 0 wins when both are ready.
          activate_next = wfifo_ready[0] ? 2'b01 : 2'b10;
          count_next    = '0;
          state_next    = WRITE;
        end else if (pending) begin
          // No buffer: consume the sample anyway so the reader is not stalled.
          ack_next = 1'b1;
          if (!(&overflow_reg)) begin
            overflow_next = overflow_reg + OVF_ONE;
          end
        end
      end

      WRITE: begin
        if (count_reg >= wfifo_size) begin
          // Covers a zero-sized buffer: hand it straight back.
          state_next = RELEASE;
        end else if (pending) begin
          strobe_next = 1'b1;
          data_next   = packed_word;
          ack_next    = 1'b1;
          count_next  = count_reg + 24'd1;
          if (count_reg + 24'd1 == wfifo_size) begin
            state_next = RELEASE;
          end
`ifdef I2S_RX_FLUSH_TIMEOUT_EN
        end else if (count_reg != 24'd0) begin
          // Partial buffer with no traffic: flush it after the timeout.
          if (idle_reg == IDLE_LAST) begin
            state_next = RELEASE;
          end else begin
            idle_next = idle_reg + IDLE_ONE;
          end
`endif
        end
      end

      RELEASE: begin
        activate_next = 2'b00;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Disable releases whatever buffer is held and silences the handshake.
    if (!enable) begin
      state_next    = IDLE;
      activate_next = 2'b00;
      strobe_next   = 1'b0;
      ack_next      = 1'b0;
      count_next    = '0;
`ifdef I2S_RX_FLUSH_TIMEOUT_EN
      idle_next     = '0;
`endif
    end

    // Clear takes priority over a simultaneous drop increment.
    if (clear_overflow) begin
      overflow_next = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      activate_reg <= 2'b00;
      strobe_reg   <= 1'b0;
      data_reg     <= '0;
      ack_reg      <= 1'b0;
      overflow_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      activate_reg <= activate_next;
      strobe_reg   <= strobe_next;
      data_reg     <= data_next;
      ack_reg      <= ack_next;
      overflow_reg <= overflow_next;
    end
  end

`ifdef I2S_RX_FLUSH_TIMEOUT_EN
  // Idle counter since the last strobe, only meaningful in WRITE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_reg <= '0;
    end else begin
      idle_reg <= idle_next;
    end
  end
`endif

  assign audio_data_ack = ack_reg;
  assign wfifo_activate = activate_reg;
  assign wfifo_strobe   = strobe_reg;
  assign wfifo_data     = data_reg;
  assign overflow_count = overflow_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_i2s_rx_mem_controller.sv
// Directed self-checking bench for i2s_rx_mem_controller.
// Uses a 4-bit overflow counter so saturation can be reached quickly.
module tb_i2s_rx_mem_controller;

  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear_overflow;
  logic          audio_data_request;
  logic [23:0]   audio_data;
  logic          audio_lr_bit;
  logic          audio_data_ack;
  logic [1:0]    wfifo_ready;
  logic [23:0]   wfifo_size;
  logic [1:0]    wfifo_activate;
  logic          wfifo_strobe;
  logic [31:0]   wfifo_data;
  logic [OW-1:0] overflow_count;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] strobe_q[$];

  i2s_rx_mem_controller #(.FLUSH_TIMEOUT(16), .OVERFLOW_WIDTH(OW)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .clear_overflow    (clear_overflow),
    .audio_data_request(audio_data_request),
    .audio_data        (audio_data),
    .audio_lr_bit      (audio_lr_bit),
    .audio_data_ack    (audio_data_ack),
    .wfifo_ready       (wfifo_ready),
    .wfifo_size        (wfifo_size),
    .wfifo_activate    (wfifo_activate),
    .wfifo_strobe      (wfifo_strobe),
    .wfifo_data        (wfifo_data),
    .overflow_count    (overflow_count),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase transfer of one sample, with bounded waits.
  task automatic send(input logic [23:0] d, input logic lr);
    logic got;
    audio_data         = d;
    audio_lr_bit       = lr;
    audio_data_request = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (audio_data_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    audio_data_request = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!audio_data_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_release", {31'd0, got}, 32'd1);
  endtask

  // Capture every written word; a strobe must always coincide with ack.
  always @(negedge clk) begin
    if (wfifo_strobe) begin
      strobe_q.push_back(wfifo_data);
      check("strobe_with_ack", {31'd0, audio_data_ack}, 32'd1);
      $display("write word %h (total %0d)", wfifo_data, strobe_q.size());
    end
  end

  initial begin
    int base;
    rst = 1'b0; enable = 1'b0; clear_overflow = 1'b0;
    audio_data_request = 1'b0; audio_data = '0; audio_lr_bit = 1'b0;
    wfifo_ready = 2'b00; wfifo_size = '0;
    tick(); tick(); tick();
    check("rst_ack",      {31'd0, audio_data_ack}, 32'd0);
    check("rst_activate", {30'd0, wfifo_activate}, 32'd0);
    check("rst_strobe",   {31'd0, wfifo_strobe},   32'd0);
    check("rst_data",     wfifo_data,              32'd0);
    check("rst_overflow", {28'd0, overflow_count}, 32'd0);
    check("rst_busy",     {31'd0, busy},           32'd0);

    // Single buffer of 4 words.
    rst = 1'b1; enable = 1'b1; wfifo_ready = 2'b01; wfifo_size = 24'd4;
    tick();
    check("t1_grant", {30'd0, wfifo_activate}, 32'd1);
    check("t1_busy",  {31'd0, busy},           32'd1);
    send(24'h000001, 1'b0);
    send(24'h000002, 1'b1);
    send(24'h000003, 1'b0);
    send(24'h000004, 1'b1);
    wfifo_ready = 2'b00;
    check("t1_released", {30'd0, wfifo_activate}, 32'd0);
    tick();
    check("t1_still_low", {30'd0, wfifo_activate}, 32'd0);
    check("t1_count", strobe_q.size(), 32'd4);
    check("t1_w0", strobe_q[0], 32'h00000001);
    check("t1_w1", strobe_q[1], 32'h80000002);
    check("t1_w2", strobe_q[2], 32'h00000003);
    check("t1_w3", strobe_q[3], 32'h80000004);

    // Both buffers ready -> buffer 0; then only buffer 1.
    wfifo_ready = 2'b11; wfifo_size = 24'd2;
    tick();
    check("t2_grant0", {30'd0, wfifo_activate}, 32'd1);
    wfifo_ready = 2'b10;
    send(24'h123456, 1'b0);
    send(24'hABCDEF, 1'b1);
    check("t2_gap", {30'd0, wfifo_activate}, 32'd0);
    tick();
    check("t2_grant1", {30'd0, wfifo_activate}, 32'd2);
    send(24'h000FFF, 1'b0);
    send(24'hFFFFFF, 1'b1);
    wfifo_ready = 2'b00;
    check("t2_released", {30'd0, wfifo_activate}, 32'd0);
    check("t2_count", strobe_q.size(), 32'd8);
    check("t2_w4", strobe_q[4], 32'h00123456);
    check("t2_w5", strobe_q[5], 32'h80ABCDEF);
    check("t2_w6", strobe_q[6], 32'h00000FFF);
    check("t2_w7", strobe_q[7], 32'h80FFFFFF);
    check("t2_no_drop", {28'd0, overflow_count}, 32'd0);

    // No buffer: drops, clear, clear-vs-increment, saturation.
    tick();
    send(24'h000011, 1'b0);
    send(24'h000022, 1'b1);
    send(24'h000033, 1'b0);
    check("t3_ovf3", {28'd0, overflow_count}, 32'd3);
    check("t3_no_strobe", strobe_q.size(), 32'd8);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_cleared", {28'd0, overflow_count}, 32'd0);
    send(24'h000044, 1'b1);
    check("t3_ovf1", {28'd0, overflow_count}, 32'd1);
    audio_data_request = 1'b1; clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_clear_wins_ack", {31'd0, audio_data_ack}, 32'd1);
    check("t3_clear_wins", {28'd0, overflow_count}, 32'd0);
    audio_data_request = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) send(24'h000055, 1'b0);
    check("t3_saturated", {28'd0, overflow_count}, 32'd15);

    // Request held for 5 cycles -> one take.
    wfifo_ready = 2'b01; wfifo_size = 24'd4;
    tick();
    check("t4_grant", {30'd0, wfifo_activate}, 32'd1);
    wfifo_ready = 2'b00;
    base = strobe_q.size();
    audio_data = 24'h5A5A5A; audio_lr_bit = 1'b1; audio_data_request = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t4_ack_held", {31'd0, audio_data_ack}, 32'd1);
    check("t4_one_strobe", strobe_q.size(), base + 1);
    check("t4_word", strobe_q[base], 32'h805A5A5A);
    audio_data_request = 1'b0;
    tick();
    check("t4_ack_fall", {31'd0, audio_data_ack}, 32'd0);
`ifndef I2S_RX_FLUSH_TIMEOUT_EN
    for (int i = 0; i < 40; i++) tick();
    check("t4_no_flush", {30'd0, wfifo_activate}, 32'd1);
`endif

    // Enable drop after 2 words, then reset mid-buffer.
    send(24'h000010, 1'b0);
    check("t5_two_words", strobe_q.size(), 32'd10);
    enable = 1'b0;
    tick();
    check("t5_en_activate", {30'd0, wfifo_activate}, 32'd0);
    check("t5_en_busy",     {31'd0, busy},           32'd0);
    check("t5_en_ovf_held", {28'd0, overflow_count}, 32'd15);
    enable = 1'b1; wfifo_ready = 2'b01;
    tick();
    check("t5_regrant", {30'd0, wfifo_activate}, 32'd1);
    wfifo_ready = 2'b00;
    send(24'h000020, 1'b0);
    check("t5_w10", strobe_q[10], 32'h00000020);
    audio_data_request = 1'b1;
    rst = 1'b0;
    tick();
    check("t5_rst_activate", {30'd0, wfifo_activate}, 32'd0);
    check("t5_rst_ack",      {31'd0, audio_data_ack}, 32'd0);
    check("t5_rst_data",     wfifo_data,              32'd0);
    check("t5_rst_ovf",      {28'd0, overflow_count}, 32'd0);
    check("t5_rst_busy",     {31'd0, busy},           32'd0);

    // Zero-sized buffer: no strobe, request stalls; then dropped when no buffer.
    rst = 1'b1; wfifo_size = 24'd0; wfifo_ready = 2'b01;
    base = strobe_q.size();
    for (int i = 0; i < 8; i++) tick();
    check("t6_zero_no_ack", {31'd0, audio_data_ack}, 32'd0);
    check("t6_zero_no_strobe", strobe_q.size(), base);
    wfifo_ready = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    check("t6_drop_ack", {31'd0, audio_data_ack}, 32'd1);
    check("t6_drop_ovf", {28'd0, overflow_count}, 32'd1);
    audio_data_request = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
